// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell reused LSB-first over WIDTH cycles.
// Latency: start sampled in cycle 0, busy in cycles 1..WIDTH, done pulse in cycle WIDTH+1.
// Backpressure: none; start is ignored while busy and results are held until the next done.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] res;
    logic [CW-1:0]    cnt;
    logic             carry;

    logic             bit_s;
    logic             bit_c;
    logic [WIDTH:0]   res_cat;
    logic [WIDTH-1:0] res_next;

    assign bit_s    = op_a[0] ^ op_b[0] ^ carry;
    assign bit_c    = (op_a[0] & op_b[0]) | (op_a[0] & carry) | (op_b[0] & carry);
    // New bit enters at the MSB; slicing the concatenation also covers WIDTH=1.
    assign res_cat  = {bit_s, res};
    assign res_next = res_cat[WIDTH:1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
            op_a  <= '0;
            op_b  <= '0;
            res   <= '0;
            cnt   <= '0;
            carry <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        // Subtraction is a + ~b + 1, so the inverted operand and carry seed do it.
                        op_a  <= a;
                        op_b  <= sub ? ~b : b;
                        carry <= sub ? 1'b1 : cin;
                        res   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= S_RUN;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    op_a  <= op_a >> 1;
                    op_b  <= op_b >> 1;
                    res   <= res_next;
                    carry <= bit_c;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST_BIT) begin
                        // carry here is the carry into the MSB, bit_c the carry out of it.
                        sum   <= res_next;
                        cout  <= bit_c;
                        ovf   <= carry ^ bit_c;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
